// File: rtl/tankb_shell_gen.sv
// Tank Battalion shell generator: hblank scan of the shell registers into a
// double-buffered per-line list, then a registered per-pixel compare.
module tankb_shell_gen #(
  parameter int NSHELL       = 8,
  parameter int SHELL_W      = 2,
  parameter int SHELL_H      = 2,
  parameter int MAX_PER_LINE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic [7:0] hcnt,
  input  logic [7:0] vcnt,
  input  logic       hblank,
  input  logic       vblank,
  input  logic       cpu_wr,
  input  logic [3:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic       shell_pix,
  output logic [2:0] shell_idx,
  output logic       overflow
);

  localparam int CW = $clog2(MAX_PER_LINE + 1);
  localparam int SW = $clog2(MAX_PER_LINE);
  localparam logic [7:0] SH8 = 8'(SHELL_H);
  localparam logic [7:0] SW8 = 8'(SHELL_W);
  localparam logic [2:0] LAST = 3'(NSHELL - 1);
  localparam logic [CW-1:0] FULL = CW'(MAX_PER_LINE);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, state_n;

  logic [7:0]    xr   [NSHELL];
  logic [7:0]    yr   [NSHELL];
  logic [2:0]    scan_idx;
  logic [7:0]    nx_x [MAX_PER_LINE];
  logic [2:0]    nx_i [MAX_PER_LINE];
  logic [CW-1:0] nx_cnt;
  logic [7:0]    cu_x [MAX_PER_LINE];
  logic [2:0]    cu_i [MAX_PER_LINE];
  logic [CW-1:0] cu_cnt;
  logic          hblank_d, vblank_d;
  logic          hb_rise, hb_fall, vb_rise;
  logic [7:0]    dy;
  logic          scan_hit, ovf_set;
  logic          hit_any;
  logic [2:0]    hit_idx;

  assign hb_rise = hblank & ~hblank_d;
  assign hb_fall = ~hblank & hblank_d;
  assign vb_rise = vblank & ~vblank_d;

  // target line is vcnt+1; 8-bit difference makes 255->0 wrap free
  assign dy = vcnt + 8'd1 - yr[scan_idx];
  assign scan_hit = (state == SCAN) && (yr[scan_idx] != 8'd0) &&
                    (dy < SH8);

  // a list cut short by hblank falling mid-scan counts as overflow
  assign ovf_set = (hb_fall && state == SCAN) ||
                   (!hb_fall && scan_hit && nx_cnt == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSHELL; i++) begin
        xr[i] <= '0;
        yr[i] <= '0;
      end
    end else if (cpu_wr) begin
      if (cpu_addr[0]) yr[cpu_addr[3:1]] <= cpu_din;
      else             xr[cpu_addr[3:1]] <= cpu_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (hb_rise) state_n = SCAN;
      SCAN: begin
        if (hb_fall)               state_n = IDLE;
        else if (scan_idx == LAST) state_n = DONE;
      end
      DONE: if (hb_fall) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_idx <= '0;
      hblank_d <= 1'b0;
      vblank_d <= 1'b0;
    end else begin
      scan_idx <= (state == SCAN) ? scan_idx + 3'd1 : 3'd0;
      hblank_d <= hblank;
      vblank_d <= vblank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nx_cnt <= '0;
      cu_cnt <= '0;
      for (int s = 0; s < MAX_PER_LINE; s++) begin
        nx_x[s] <= '0;
        nx_i[s] <= '0;
        cu_x[s] <= '0;
        cu_i[s] <= '0;
      end
    end else if (hb_fall) begin
      cu_x   <= nx_x;
      cu_i   <= nx_i;
      cu_cnt <= nx_cnt;
      nx_cnt <= '0;
    end else if (scan_hit && nx_cnt != FULL) begin
      nx_x[nx_cnt[SW-1:0]] <= xr[scan_idx];
      nx_i[nx_cnt[SW-1:0]] <= scan_idx;
      nx_cnt <= nx_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (vb_rise) overflow <= 1'b0;
  end

  // list is filled in ascending index order, so lowest slot wins
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int s = MAX_PER_LINE - 1; s >= 0; s--) begin
      if (CW'(s) < cu_cnt && (hcnt - cu_x[s]) < SW8) begin
        hit_any = 1'b1;
        hit_idx = cu_i[s];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shell_pix <= 1'b0;
      shell_idx <= '0;
    end else if (pix_en) begin
      if (!hblank && !vblank) begin
        shell_pix <= hit_any;
        shell_idx <= hit_idx;
      end else begin
        shell_pix <= 1'b0;
        shell_idx <= '0;
      end
    end
  end

endmodule

// File: doc/tankb_shell_gen.md
# tankb_shell_gen

Hardware shell (bullet) generator for the Tank Battalion video path. The CPU writes X/Y positions for up to 8 shells into a small register file. During each horizontal blank a scan state machine builds the list of shells visible on the next line. During active video a per-pixel comparator drives a shell-pixel flag into the colour mixer, alongside the tile pixel coming out of the palette PROM stage.

## Interface
Parameters:
- NSHELL, 8, number of shell register pairs; index width is 3.
- SHELL_W, 2, shell width in pixels.
- SHELL_H, 2, shell height in lines.
- MAX_PER_LINE, 4, visible shells stored per line.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- pix_en  in  1  one-clk pixel enable, 6 MHz rate.
- hcnt  in  8  horizontal pixel position; valid when pix_en is high.
- vcnt  in  8  current line number.
- hblank  in  1  horizontal blank.
- vblank  in  1  vertical blank.
- cpu_wr  in  1  register write strobe, one clk.
- cpu_addr  in  4  bits [3:1] select the shell index; bit 0 selects field: 0 = X, 1 = Y.
- cpu_din  in  8  write data.
- shell_pix  out  1  shell pixel present.
- shell_idx  out  3  index of the lowest-numbered shell hit.
- overflow  out  1  sticky flag: more than MAX_PER_LINE shells hit on a line.

## Operation
- **Register file.** 8 X and 8 Y bytes. A write lands on the clk where cpu_wr is high. A shell is disabled when its Y = 0.
- **Target line.** T = (vcnt + 1) mod 256.
- **Hit rule.** Shell i hits the line when Y[i] != 0 and ((T - Y[i]) mod 256) < SHELL_H. The subtraction is 8-bit, so wrap-around across line 255→0 is legal.
- **Scan FSM states:**
  - IDLE → SCAN on the clk after hblank rises.
  - SCAN reads one entry per clk, index 0..7 ascending, using the live register value.
  - SCAN → DONE after index 7.
  - DONE → IDLE when hblank falls.
- **List fill.** Each hit is appended to the "next" list as {index, X}, in ascending index order.
- **Overflow.** A hit found when the next list already holds MAX_PER_LINE entries is dropped and sets overflow. overflow is cleared on the rising edge of vblank.
- **Double buffer.** On the clk after hblank falls, "next" is copied to "current" and "next" is emptied.
  - If SCAN has not completed at that point, the partial list is used, the remaining entries are dropped, the FSM returns to IDLE, and overflow is set.
- **Render.** On a clk where pix_en = 1, hblank = 0 and vblank = 0, slot s of the current list hits when ((hcnt - X[s]) mod 256) < SHELL_W.
  - shell_pix = OR of all slot hits.
  - shell_idx = index of the valid slot with the lowest shell index.
  - With no hit, or on a non-qualifying pix_en, shell_pix = 0 and shell_idx = 0.
- **Blanking.** During vblank, scanning still runs, so line 0's list is ready at the end of vblank. Render output is forced to 0.

## Timing
- **Reset values.** All X/Y = 0; both lists empty; FSM = IDLE; shell_pix = 0; shell_idx = 0; overflow = 0.
- **Render latency.** shell_pix/shell_idx are registered and update on the clk after the qualifying pix_en clk. They hold their value until the next pix_en clk.
- **Scan duration.** Exactly NSHELL clks after entering SCAN.
- **Write during SCAN.**
  - A write to an entry not yet scanned is used this scan.
  - A write to an entry already scanned takes effect on the next line.
  - A write on the same clk the entry is scanned uses the old value.
- **Simultaneous events.**
  - hblank fall and a scan hit on the same clk: the swap takes priority and the hit is dropped.
  - vblank rise and an overflow set on the same clk: set wins.
- **Reset mid-scan.** Asynchronous reset returns everything to reset values immediately.
  - After release, the first swap delivers an empty list unless a full scan completes in between.

## Test plan
- **Single shell, render position.**
  - Stimulus: reset; write X[0] = 0x40, Y[0] = 0x20; run a frame.
  - Required: shell_pix = 1 exactly for hcnt 0x40–0x41 on lines 0x20–0x21 (the pix_en after hcnt=0x40 through the pix_en after 0x41), with shell_idx = 0.
  - Required: shell_pix = 0 everywhere else.
- **Overlap priority.**
  - Stimulus: shells 3 and 5 both at X = 0x80, Y = 0x50.
  - Required: shell_pix = 1 and shell_idx = 3 on the overlapping pixels.
- **Overflow.**
  - Stimulus: all 8 shells at Y = 0x30, X = 0x10·i.
  - Required: only shells 0–3 render on line 0x30; overflow = 1 from that hblank until the next vblank rise, then 0.
- **Wrap-around.**
  - Stimulus: Y[1] = 0xFF, X[1] = 0xFF.
  - Required: shell 1 renders on lines 0xFF and 0x00 at hcnt 0xFF and 0x00.
- **Write races.**
  - Stimulus: rewrite Y[7] in the 3rd clk of SCAN.
  - Required: the new value is used on the following line.
  - Stimulus: rewrite Y[0] in the 3rd clk of SCAN.
  - Required: the old Y[0] value is used this line; the new value applies on the line after.
- **Reset mid-operation.**
  - Stimulus: assert rst mid-SCAN, then release.
  - Required: all outputs 0 immediately; no shell renders until the X/Y registers are rewritten.
